// File: rtl/rx_pkg.sv
// rtl/rx_pkg.sv - shared types and constants for the receiver frame path
package rx_pkg;

  typedef enum logic [1:0] {
    HUNT    = 2'd0,
    PAYLOAD = 2'd1,
    PARITY  = 2'd2
  } state_t;

  localparam logic [7:0] SYNC_WORD_DEF = 8'hD5;
  localparam int         DROP_CNT_W    = 8;

endpackage

// File: rtl/rx_frame_buf.sv
// rtl/rx_frame_buf.sv - single-entry valid/ready holding register with drop flag
module rx_frame_buf #(
  parameter int W = 12
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         load,
  input  logic [W-1:0] load_data,
  input  logic         rdy,
  output logic [W-1:0] data,
  output logic         vld,
  output logic         drop
);

  // A load is refused only when the entry is full and not draining this edge.
  assign drop = load && vld && !rdy;

  // Hold the entry until handshake; a same-edge load replaces the drained frame.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      data <= '0;
      vld  <= 1'b0;
    end else if (load && (!vld || rdy)) begin
      data <= load_data;
      vld  <= 1'b1;
    end else if (vld && rdy) begin
      vld  <= 1'b0;
    end
  end

endmodule

// File: rtl/rx_frame_decoder.sv
// rtl/rx_frame_decoder.sv - sync hunt and payload deserializer; RX_FRAME_PARITY_EN adds an even-parity bit
module rx_frame_decoder
  import rx_pkg::*;
#(
  parameter int                SYNC_W    = 8,
  parameter logic [SYNC_W-1:0] SYNC_WORD = SYNC_W'(SYNC_WORD_DEF),
  parameter int                PAYLOAD_W = 12,
  parameter int                TIMEOUT   = 64
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  bit_in,
  input  logic                  bit_vld,
  output logic [PAYLOAD_W-1:0]  frm_data,
  output logic                  frm_vld,
  input  logic                  frm_rdy,
  output logic                  sync_lock,
  output logic [DROP_CNT_W-1:0] drop_cnt
);

  localparam int                IDLE_W   = $clog2(TIMEOUT + 1);
  localparam int                BCNT_W   = $clog2(PAYLOAD_W);
  localparam logic [IDLE_W-1:0] IDLE_MAX = IDLE_W'(TIMEOUT - 1);
  localparam logic [BCNT_W-1:0] LAST     = BCNT_W'(PAYLOAD_W - 1);
`ifdef RX_FRAME_PARITY_EN
  // The full payload must stay visible for the parity bit that follows it.
  localparam int SHR_W = PAYLOAD_W;
`else
  // The final bit is taken straight from bit_in, so one bit less is stored.
  localparam int SHR_W = PAYLOAD_W - 1;
`endif

  state_t             state;
  logic [SYNC_W-2:0]  window;
  logic [SYNC_W-1:0]  window_nxt;
  logic [SHR_W-1:0]   shreg;
  logic [PAYLOAD_W-1:0] payload_nxt;
  logic [BCNT_W-1:0]  bit_cnt;
  logic [IDLE_W-1:0]  idle_cnt;
  logic               timeout;
  logic               commit;
  logic               par_err;
  logic [PAYLOAD_W-1:0] commit_data;
  logic               buf_drop;
  logic               drop_evt;

  assign window_nxt  = {window, bit_in};
  assign payload_nxt = {shreg[PAYLOAD_W-2:0], bit_in};
  assign timeout     = (state != HUNT) && !bit_vld && (idle_cnt == IDLE_MAX);

`ifdef RX_FRAME_PARITY_EN
  assign commit      = (state == PARITY) && bit_vld && ((^shreg) == bit_in);
  assign par_err     = (state == PARITY) && bit_vld && ((^shreg) != bit_in);
  assign commit_data = shreg;
`else
  assign commit      = (state == PAYLOAD) && bit_vld && (bit_cnt == LAST);
  assign par_err     = 1'b0;
  assign commit_data = payload_nxt;
`endif

  // These sources are mutually exclusive in time, so one increment suffices.
  assign drop_evt = buf_drop || timeout || par_err;

  // Frame FSM: hunt for sync, shift payload, optionally check parity.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state     <= HUNT;
      window    <= '0;
      shreg     <= '0;
      bit_cnt   <= '0;
      idle_cnt  <= '0;
      sync_lock <= 1'b0;
    end else begin
      case (state)
        HUNT: begin
          if (bit_vld) begin
            if (window_nxt == SYNC_WORD) begin
              state     <= PAYLOAD;
              sync_lock <= 1'b1;
              window    <= '0;
              bit_cnt   <= '0;
              idle_cnt  <= '0;
            end else begin
              window <= window_nxt[SYNC_W-2:0];
            end
          end
        end
        PAYLOAD: begin
          if (bit_vld) begin
            shreg    <= payload_nxt[SHR_W-1:0];
            idle_cnt <= '0;
            if (bit_cnt == LAST) begin
              bit_cnt <= '0;
`ifdef RX_FRAME_PARITY_EN
              state   <= PARITY;
`else
              state     <= HUNT;
              sync_lock <= 1'b0;
`endif
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end else if (timeout) begin
            state     <= HUNT;
            sync_lock <= 1'b0;
            idle_cnt  <= '0;
            bit_cnt   <= '0;
          end else begin
            idle_cnt <= idle_cnt + 1'b1;
          end
        end
        PARITY: begin
          if (bit_vld || timeout) begin
            state     <= HUNT;
            sync_lock <= 1'b0;
            idle_cnt  <= '0;
          end else begin
            idle_cnt <= idle_cnt + 1'b1;
          end
        end
        default: begin
          state     <= HUNT;
          sync_lock <= 1'b0;
        end
      endcase
    end
  end

  // Saturating count of frames lost to overflow, timeout or parity.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      drop_cnt <= '0;
    end else if (drop_evt && (drop_cnt != {DROP_CNT_W{1'b1}})) begin
      drop_cnt <= drop_cnt + 1'b1;
    end
  end

  rx_frame_buf #(.W(PAYLOAD_W)) u_buf (
    .clk       (clk),
    .rstn      (rstn),
    .load      (commit),
    .load_data (commit_data),
    .rdy       (frm_rdy),
    .data      (frm_data),
    .vld       (frm_vld),
    .drop      (buf_drop)
  );

endmodule

// File: tb/tb_rx_frame_decoder.sv
// tb/tb_rx_frame_decoder.sv - directed self-checking bench for rx_frame_decoder
module tb_rx_frame_decoder;

  logic        clk;
  logic        rstn;
  logic        bit_in;
  logic        bit_vld;
  logic [11:0] frm_data;
  logic        frm_vld;
  logic        frm_rdy;
  logic        sync_lock;
  logic [7:0]  drop_cnt;

  int          checks;
  int          errors;
  logic [7:0]  exp_drop;
  localparam logic [7:0] SYNC = 8'hD5;

  rx_frame_decoder dut (
    .clk       (clk),
    .rstn      (rstn),
    .bit_in    (bit_in),
    .bit_vld   (bit_vld),
    .frm_data  (frm_data),
    .frm_vld   (frm_vld),
    .frm_rdy   (frm_rdy),
    .sync_lock (sync_lock),
    .drop_cnt  (drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // One bit every 4 cycles; returns at the negedge right after the accepting edge.
  task automatic send_bit(input logic b, input logic rdy);
    repeat (2) @(negedge clk);
    @(negedge clk);
    bit_in  = b;
    bit_vld = 1'b1;
    frm_rdy = rdy;
    @(negedge clk);
    bit_vld = 1'b0;
    bit_in  = 1'b0;
    frm_rdy = 1'b0;
  endtask

  // Sync word + payload (+ parity bit when enabled); rdy_last asserts frm_rdy on the commit bit.
  task automatic send_frame(input logic [11:0] p, input logic rdy_last, input logic par_flip);
    for (int i = 7; i >= 0; i--) send_bit(SYNC[i], 1'b0);
`ifdef RX_FRAME_PARITY_EN
    for (int i = 11; i >= 0; i--) send_bit(p[i], 1'b0);
    send_bit((^p) ^ par_flip, rdy_last);
`else
    for (int i = 11; i >= 1; i--) send_bit(p[i], 1'b0);
    send_bit(p[0], rdy_last);
    if (par_flip) ;
`endif
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (frm_vld !== 1'b0) begin errors++; $display("FAIL reset_frm_vld: got %b expected 0", frm_vld); end
    checks++; if (frm_data !== 12'h000) begin errors++; $display("FAIL reset_frm_data: got %h expected 000", frm_data); end
    checks++; if (sync_lock !== 1'b0) begin errors++; $display("FAIL reset_sync_lock: got %b expected 0", sync_lock); end
    checks++; if (drop_cnt !== 8'h00) begin errors++; $display("FAIL reset_drop_cnt: got %h expected 00", drop_cnt); end
    rstn = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    logic [11:0] p;
    p = 12'h5A3;
    for (int i = 7; i >= 0; i--) begin
      send_bit(SYNC[i], 1'b0);
      if (i == 1) begin
        checks++; if (sync_lock !== 1'b0) begin errors++; $display("FAIL basic_lock_early: got %b expected 0", sync_lock); end
      end
    end
    checks++; if (sync_lock !== 1'b1) begin errors++; $display("FAIL basic_lock_8th: got %b expected 1", sync_lock); end
    for (int i = 11; i >= 1; i--) send_bit(p[i], 1'b0);
    checks++; if (frm_vld !== 1'b0) begin errors++; $display("FAIL basic_vld_early: got %b expected 0", frm_vld); end
    send_bit(p[0], 1'b0);
`ifdef RX_FRAME_PARITY_EN
    send_bit(^p, 1'b0);
`endif
    checks++; if (frm_vld !== 1'b1) begin errors++; $display("FAIL basic_vld: got %b expected 1", frm_vld); end
    checks++; if (frm_data !== 12'h5A3) begin errors++; $display("FAIL basic_data: got %h expected 5a3", frm_data); end
    checks++; if (drop_cnt !== exp_drop) begin errors++; $display("FAIL basic_drop: got %h expected %h", drop_cnt, exp_drop); end
    checks++; if (sync_lock !== 1'b0) begin errors++; $display("FAIL basic_unlock: got %b expected 0", sync_lock); end
    frm_rdy = 1'b1;
    @(negedge clk);
    frm_rdy = 1'b0;
    checks++; if (frm_vld !== 1'b0) begin errors++; $display("FAIL basic_consume: got %b expected 0", frm_vld); end
  endtask

  task automatic test_noise();
    logic [7:0]  noise;
    logic [11:0] p;
    noise = 8'hAB;
    p     = 12'hFFF;
    for (int i = 7; i >= 0; i--) begin
      send_bit(noise[i], 1'b0);
      checks++; if (sync_lock !== 1'b0) begin errors++; $display("FAIL noise_lock_bit%0d: got %b expected 0", i, sync_lock); end
    end
    for (int i = 7; i >= 1; i--) begin
      send_bit(SYNC[i], 1'b0);
      checks++; if (sync_lock !== 1'b0) begin errors++; $display("FAIL noise_sync_lock_bit%0d: got %b expected 0", i, sync_lock); end
    end
    send_bit(SYNC[0], 1'b0);
    checks++; if (sync_lock !== 1'b1) begin errors++; $display("FAIL noise_lock: got %b expected 1", sync_lock); end
    for (int i = 11; i >= 0; i--) send_bit(p[i], 1'b0);
`ifdef RX_FRAME_PARITY_EN
    send_bit(^p, 1'b0);
`endif
    checks++; if (frm_vld !== 1'b1) begin errors++; $display("FAIL noise_vld: got %b expected 1", frm_vld); end
    checks++; if (frm_data !== 12'hFFF) begin errors++; $display("FAIL noise_data: got %h expected fff", frm_data); end
    frm_rdy = 1'b1;
    @(negedge clk);
    frm_rdy = 1'b0;
    repeat (10) @(negedge clk);
    checks++; if (frm_vld !== 1'b0) begin errors++; $display("FAIL noise_single_frame: got %b expected 0", frm_vld); end
    checks++; if (drop_cnt !== exp_drop) begin errors++; $display("FAIL noise_drop: got %h expected %h", drop_cnt, exp_drop); end
  endtask

  task automatic test_back_to_back();
    send_frame(12'h001, 1'b0, 1'b0);
    send_frame(12'h002, 1'b0, 1'b0);
    exp_drop = exp_drop + 8'd1;
    checks++; if (frm_vld !== 1'b1) begin errors++; $display("FAIL b2b_vld: got %b expected 1", frm_vld); end
    checks++; if (frm_data !== 12'h001) begin errors++; $display("FAIL b2b_data: got %h expected 001", frm_data); end
    checks++; if (drop_cnt !== exp_drop) begin errors++; $display("FAIL b2b_drop: got %h expected %h", drop_cnt, exp_drop); end
    frm_rdy = 1'b1;
    @(negedge clk);
    frm_rdy = 1'b0;
    checks++; if (frm_vld !== 1'b0) begin errors++; $display("FAIL b2b_release: got %b expected 0", frm_vld); end
  endtask

  task automatic test_handshake_commit();
    send_frame(12'h123, 1'b0, 1'b0);
    checks++; if (frm_data !== 12'h123) begin errors++; $display("FAIL hs_first_data: got %h expected 123", frm_data); end
    send_frame(12'h456, 1'b1, 1'b0);
    checks++; if (frm_vld !== 1'b1) begin errors++; $display("FAIL hs_vld: got %b expected 1", frm_vld); end
    checks++; if (frm_data !== 12'h456) begin errors++; $display("FAIL hs_data: got %h expected 456", frm_data); end
    checks++; if (drop_cnt !== exp_drop) begin errors++; $display("FAIL hs_drop: got %h expected %h", drop_cnt, exp_drop); end
    frm_rdy = 1'b1;
    @(negedge clk);
    frm_rdy = 1'b0;
    checks++; if (frm_vld !== 1'b0) begin errors++; $display("FAIL hs_release: got %b expected 0", frm_vld); end
  endtask

  task automatic test_timeout();
    logic [4:0] part;
    part = 5'b10110;
    for (int i = 7; i >= 0; i--) send_bit(SYNC[i], 1'b0);
    for (int i = 4; i >= 0; i--) send_bit(part[i], 1'b0);
    repeat (60) @(negedge clk);
    checks++; if (sync_lock !== 1'b1) begin errors++; $display("FAIL to_lock_held: got %b expected 1", sync_lock); end
    repeat (10) @(negedge clk);
    exp_drop = exp_drop + 8'd1;
    checks++; if (sync_lock !== 1'b0) begin errors++; $display("FAIL to_unlock: got %b expected 0", sync_lock); end
    checks++; if (drop_cnt !== exp_drop) begin errors++; $display("FAIL to_drop: got %h expected %h", drop_cnt, exp_drop); end
    checks++; if (frm_vld !== 1'b0) begin errors++; $display("FAIL to_no_frame: got %b expected 0", frm_vld); end
    send_frame(12'hA5C, 1'b0, 1'b0);
    checks++; if (frm_data !== 12'hA5C || frm_vld !== 1'b1) begin errors++; $display("FAIL to_recover: got %h/%b expected a5c/1", frm_data, frm_vld); end
    frm_rdy = 1'b1;
    @(negedge clk);
    frm_rdy = 1'b0;
  endtask

`ifdef RX_FRAME_PARITY_EN
  task automatic test_parity();
    send_frame(12'h5A3, 1'b0, 1'b1);
    exp_drop = exp_drop + 8'd1;
    checks++; if (frm_vld !== 1'b0) begin errors++; $display("FAIL par_bad_vld: got %b expected 0", frm_vld); end
    checks++; if (drop_cnt !== exp_drop) begin errors++; $display("FAIL par_bad_drop: got %h expected %h", drop_cnt, exp_drop); end
    checks++; if (sync_lock !== 1'b0) begin errors++; $display("FAIL par_bad_unlock: got %b expected 0", sync_lock); end
    send_frame(12'h5A3, 1'b0, 1'b0);
    checks++; if (frm_vld !== 1'b1 || frm_data !== 12'h5A3) begin errors++; $display("FAIL par_good: got %h/%b expected 5a3/1", frm_data, frm_vld); end
    checks++; if (drop_cnt !== exp_drop) begin errors++; $display("FAIL par_good_drop: got %h expected %h", drop_cnt, exp_drop); end
    frm_rdy = 1'b1;
    @(negedge clk);
    frm_rdy = 1'b0;
  endtask
`endif

  task automatic test_reset_mid_frame();
    logic [4:0] part;
    part = 5'b01101;
    send_frame(12'h3C3, 1'b0, 1'b0);
    for (int i = 7; i >= 0; i--) send_bit(SYNC[i], 1'b0);
    for (int i = 4; i >= 0; i--) send_bit(part[i], 1'b0);
    checks++; if (sync_lock !== 1'b1 || frm_vld !== 1'b1) begin errors++; $display("FAIL mid_pre: got lock %b vld %b expected 1 1", sync_lock, frm_vld); end
    rstn = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    exp_drop = 8'h00;
    checks++; if (sync_lock !== 1'b0) begin errors++; $display("FAIL mid_lock: got %b expected 0", sync_lock); end
    checks++; if (frm_vld !== 1'b0) begin errors++; $display("FAIL mid_vld: got %b expected 0", frm_vld); end
    checks++; if (frm_data !== 12'h000) begin errors++; $display("FAIL mid_data: got %h expected 000", frm_data); end
    checks++; if (drop_cnt !== exp_drop) begin errors++; $display("FAIL mid_drop: got %h expected 00", drop_cnt); end
    send_frame(12'h81E, 1'b0, 1'b0);
    checks++; if (frm_vld !== 1'b1 || frm_data !== 12'h81E) begin errors++; $display("FAIL mid_after: got %h/%b expected 81e/1", frm_data, frm_vld); end
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    exp_drop = 8'h00;
    rstn     = 1'b0;
    bit_in   = 1'b0;
    bit_vld  = 1'b0;
    frm_rdy  = 1'b0;
    test_reset();
    test_basic();
    test_noise();
    test_back_to_back();
    test_handshake_commit();
    test_timeout();
`ifdef RX_FRAME_PARITY_EN
    test_parity();
`endif
    test_reset_mid_frame();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
